// File: rtl/modport_bridge.sv
// AHB-Lite slave to APB master bridge for the 0x8000_0000-0x8FFF_FFFF window.
// Each accepted single transfer becomes one APB SETUP + ENABLE to one of four slaves.
module modport_bridge (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic [1:0]  Htrans,
  input  logic [2:0]  Hsize,
  input  logic        Hreadyin,
  input  logic        Hwrite,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic [31:0] Prdata,
  output logic [31:0] Hrdata,
  output logic [1:0]  Hresp,
  output logic        Hreadyout,
  output logic [3:0]  Pselx,
  output logic        Pwrite,
  output logic        Penable,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_WWAIT, S_WRITE, S_WENABLE, S_READ, S_RENABLE
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [3:0]  r_sel;
  logic [3:0]  r_psel;
  logic        r_pwrite;
  logic        r_penable;
  logic [31:0] r_paddr;
  logic [31:0] r_pwdata;
  logic        r_hready;

  logic        w_valid;
  logic [3:0]  w_sel;
  logic        w_unused;

  assign w_valid  = Hreadyin & Htrans[1] & (Haddr[31:28] == 4'h8);
  assign w_sel    = 4'b0001 << Haddr[27:26];
  assign w_unused = ^{Hsize, Htrans[0]};

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_sel     <= '0;
      r_psel    <= '0;
      r_pwrite  <= 1'b0;
      r_penable <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_hready  <= 1'b1;
    end else begin
      unique case (r_state)
        // IDLE and both ENABLE states accept the next address phase.
        S_IDLE, S_WENABLE, S_RENABLE: begin
          r_penable <= 1'b0;
          r_psel    <= '0;
          r_hready  <= 1'b1;
          r_state   <= S_IDLE;
          if (w_valid) begin
            r_addr   <= Haddr;
            r_sel    <= w_sel;
            r_hready <= 1'b0;
            if (Hwrite) begin
              r_state <= S_WWAIT;
            end else begin
              r_state  <= S_READ;
              r_psel   <= w_sel;
              r_paddr  <= Haddr;
              r_pwrite <= 1'b0;
            end
          end
        end
        // Write data arrives in the AHB data phase, one cycle after the address.
        S_WWAIT: begin
          r_pwdata <= Hwdata;
          r_psel   <= r_sel;
          r_paddr  <= r_addr;
          r_pwrite <= 1'b1;
          r_state  <= S_WRITE;
        end
        S_WRITE: begin
          r_penable <= 1'b1;
          r_hready  <= 1'b1;
          r_state   <= S_WENABLE;
        end
        S_READ: begin
          r_penable <= 1'b1;
          r_hready  <= 1'b1;
          r_state   <= S_RENABLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Pselx     = r_psel;
  assign Pwrite    = r_pwrite;
  assign Penable   = r_penable;
  assign Paddr     = r_paddr;
  assign Pwdata    = r_pwdata;
  assign Hreadyout = r_hready;
  assign Hresp     = 2'b00;
  assign Hrdata    = Prdata;

endmodule

// File: tb/tb_modport_bridge.sv
// Self-checking bench for modport_bridge: directed cases then random AHB traffic,
// compared cycle by cycle against a per-cycle APB timeline built from transfer rules.
module tb_modport_bridge;

  localparam int NCYC = 4000;

  logic        Hclk;
  logic        Hresetn;
  logic [1:0]  Htrans;
  logic [2:0]  Hsize;
  logic        Hreadyin;
  logic        Hwrite;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [31:0] Prdata;
  logic [31:0] Hrdata;
  logic [1:0]  Hresp;
  logic        Hreadyout;
  logic [3:0]  Pselx;
  logic        Pwrite;
  logic        Penable;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;

  modport_bridge dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Htrans(Htrans), .Hsize(Hsize),
    .Hreadyin(Hreadyin), .Hwrite(Hwrite), .Haddr(Haddr), .Hwdata(Hwdata),
    .Prdata(Prdata), .Hrdata(Hrdata), .Hresp(Hresp), .Hreadyout(Hreadyout),
    .Pselx(Pselx), .Pwrite(Pwrite), .Penable(Penable), .Paddr(Paddr),
    .Pwdata(Pwdata)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  int n_chk  = 0;
  int n_fail = 0;

  // Expected bus picture for each cycle index.
  logic [3:0]  exp_sel  [NCYC];
  logic        exp_en   [NCYC];
  logic        exp_rdy  [NCYC];
  logic        exp_wr   [NCYC];
  logic [31:0] exp_addr [NCYC];
  logic [31:0] exp_data [NCYC];
  logic        wcap     [NCYC];
  logic        rstchk   [NCYC];

  int   cyc   = -1;
  logic armed = 1'b0;
  logic prev_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  function automatic void set_idle(input int k);
    exp_sel[k] = 4'b0000;
    exp_en[k]  = 1'b0;
    exp_rdy[k] = 1'b1;
    exp_wr[k]  = 1'b0;
    wcap[k]    = 1'b0;
  endfunction

  function automatic void set_phase(input int k, input logic [3:0] sel, input logic en,
                                    input logic rdy, input logic wr, input logic [31:0] addr);
    exp_sel[k]  = sel;
    exp_en[k]   = en;
    exp_rdy[k]  = rdy;
    exp_wr[k]   = wr;
    exp_addr[k] = addr;
  endfunction

  // One bus cycle: drive inputs after the falling edge, check outputs, update model.
  task automatic bus_cycle(input logic rstn, input logic [1:0] trans, input logic rdyin,
                           input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] prdata);
    logic [3:0] sel;
    logic       in_win;
    @(negedge Hclk);
    cyc++;
    Hresetn  = rstn;
    Htrans   = trans;
    Hreadyin = rdyin;
    Hwrite   = wr;
    Haddr    = addr;
    Hwdata   = wdata;
    Prdata   = prdata;
    Hsize    = 3'($urandom);
    #1;
    if (armed) begin
      chk("hreadyout", 32'(Hreadyout), 32'(exp_rdy[cyc]));
      chk("pselx", 32'(Pselx), 32'(exp_sel[cyc]));
      chk("penable", 32'(Penable), 32'(exp_en[cyc]));
      chk("hresp", 32'(Hresp), 32'd0);
      chk("penable_consec", 32'(prev_en & Penable), 32'd0);
      if (exp_sel[cyc] != 4'b0000) begin
        chk("paddr", Paddr, exp_addr[cyc]);
        chk("pwrite", 32'(Pwrite), 32'(exp_wr[cyc]));
        if (exp_wr[cyc]) chk("pwdata", Pwdata, exp_data[cyc]);
      end
      if (exp_en[cyc] && !exp_wr[cyc]) chk("hrdata", Hrdata, prdata);
      if (rstchk[cyc]) begin
        chk("rst_paddr", Paddr, 32'd0);
        chk("rst_pwdata", Pwdata, 32'd0);
        chk("rst_pwrite", 32'(Pwrite), 32'd0);
      end
    end
    prev_en = Penable;

    if (wcap[cyc]) begin
      exp_data[cyc+1] = wdata;
      exp_data[cyc+2] = wdata;
    end
    sel    = 4'b0001 << addr[27:26];
    in_win = (addr[31:28] == 4'h8);
    if (!rstn) begin
      for (int k = cyc + 1; k <= cyc + 3; k++) set_idle(k);
      rstchk[cyc+1] = 1'b1;
      armed = 1'b1;
    end else if (exp_rdy[cyc] && rdyin && trans[1] && in_win) begin
      if (wr) begin
        set_phase(cyc + 1, 4'b0000, 1'b0, 1'b0, 1'b1, addr);
        set_phase(cyc + 2, sel, 1'b0, 1'b0, 1'b1, addr);
        set_phase(cyc + 3, sel, 1'b1, 1'b1, 1'b1, addr);
        wcap[cyc+1] = 1'b1;
      end else begin
        set_phase(cyc + 1, sel, 1'b0, 1'b0, 1'b0, addr);
        set_phase(cyc + 2, sel, 1'b1, 1'b1, 1'b0, addr);
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++)
      bus_cycle(1'b1, 2'b00, 1'b1, 1'b0, 32'h0, $urandom, $urandom);
  endtask

  initial begin
    for (int k = 0; k < NCYC; k++) begin
      set_idle(k);
      rstchk[k]   = 1'b0;
      exp_addr[k] = '0;
      exp_data[k] = '0;
    end
    Hresetn = 1'b0; Htrans = 2'b00; Hreadyin = 1'b1; Hwrite = 1'b0;
    Haddr = '0; Hwdata = '0; Prdata = '0; Hsize = 3'b010;

    // Reset for two cycles.
    bus_cycle(1'b0, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    bus_cycle(1'b0, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    idle_cycles(1);

    // Single write.
    bus_cycle(1'b1, 2'b10, 1'b1, 1'b1, 32'h8000_0010, 32'h0, 32'h0);
    bus_cycle(1'b1, 2'b00, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'h0);
    idle_cycles(3);

    // Single read.
    bus_cycle(1'b1, 2'b10, 1'b1, 1'b0, 32'h8800_0004, 32'h0, 32'h1234_5678);
    bus_cycle(1'b1, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h1234_5678);
    bus_cycle(1'b1, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h1234_5678);
    idle_cycles(1);

    // Decode of slaves 1 and 3.
    bus_cycle(1'b1, 2'b11, 1'b1, 1'b1, 32'h8400_0000, 32'h0, 32'h0);
    bus_cycle(1'b1, 2'b00, 1'b1, 1'b0, 32'h0, 32'hA5A5_0001, 32'h0);
    idle_cycles(2);
    bus_cycle(1'b1, 2'b10, 1'b1, 1'b1, 32'h8C00_0000, 32'h0, 32'h0);
    bus_cycle(1'b1, 2'b00, 1'b1, 1'b0, 32'h0, 32'hA5A5_0003, 32'h0);
    idle_cycles(3);

    // Ignored transfers: out of window, inactive.
    bus_cycle(1'b1, 2'b10, 1'b1, 1'b1, 32'h9000_0000, 32'h0, 32'h0);
    bus_cycle(1'b1, 2'b00, 1'b1, 1'b1, 32'h8000_0000, 32'h0, 32'h0);
    idle_cycles(3);

    // Back-to-back write then read, second address in the ENABLE cycle.
    bus_cycle(1'b1, 2'b10, 1'b1, 1'b1, 32'h8000_0000, 32'h0, 32'h0);
    bus_cycle(1'b1, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0BAD_F00D, 32'h0);
    idle_cycles(1);
    bus_cycle(1'b1, 2'b10, 1'b1, 1'b0, 32'h8400_0008, 32'h0, 32'h0);
    bus_cycle(1'b1, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'hCAFE_0008);
    bus_cycle(1'b1, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'hCAFE_0008);
    idle_cycles(1);

    // Reset asserted during the write SETUP cycle.
    bus_cycle(1'b1, 2'b10, 1'b1, 1'b1, 32'h8800_0020, 32'h0, 32'h0);
    bus_cycle(1'b1, 2'b00, 1'b1, 1'b0, 32'h0, 32'h1111_2222, 32'h0);
    bus_cycle(1'b0, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    idle_cycles(3);

    // Random traffic, including address phases offered while the bridge is busy.
    for (int i = 0; i < 2500; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 7) < 6) a = {4'h8, 28'($urandom)};
      else                          a = $urandom;
      bus_cycle(($urandom_range(0, 59) != 0), 2'($urandom), ($urandom_range(0, 7) != 0),
                1'($urandom), a, $urandom, $urandom);
    end
    idle_cycles(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
